// File: rtl/spmv_pkg.sv
// Shared definitions for the SpMV CSR loader: FSM states, geometry and the SRAM write payload.
// The optional checksum is enabled with SPMV_LOADER_CHECKSUM_EN (see spmv_csr_loader).
package spmv_pkg;

  localparam int unsigned WORD_W          = 256;
  localparam int unsigned ELEM_W          = 16;
  localparam int unsigned LANES           = 16;
  localparam int unsigned LANE_W          = 4;
  localparam int unsigned ADDR_W          = 5;
  localparam int unsigned DEF_MAX_WORDS_A = 32;
  localparam int unsigned DEF_MAX_WORDS_B = 16;
  localparam int unsigned RESULT_ADDR_B   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // One SRAM write beat as seen on the memory port
  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } sram_wr_t;

  // Smaller of two word limits; used to keep the reserved result slot unreachable
  function automatic int unsigned min_words(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/spmv_word_packer.sv
// Packs 16-bit elements into 256-bit words and emits one registered SRAM write per full
// (or flushed partial) word, stopping at MAX_WORDS and reporting elements dropped when full.
module spmv_word_packer
  import spmv_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 16
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_clear,
  input  logic              i_accept,
  input  logic [ELEM_W-1:0] i_data,
  input  logic              i_flush,
  output logic              o_drop_c,
  output sram_wr_t          o_wr
);

  localparam int unsigned CNT_W  = $clog2(MAX_WORDS + 1);
  localparam int unsigned BASE_W = $clog2(WORD_W);

  logic [LANE_W-1:0] r_lane;
  logic [WORD_W-1:0] r_buf;
  logic [CNT_W-1:0]  r_word_cnt;
  sram_wr_t          r_wr;

  logic              w_full;
  logic              w_store;
  logic              w_complete;
  logic              w_flush_wr;
  logic [BASE_W-1:0] w_base;
  logic [WORD_W-1:0] w_packed;

  assign w_full     = (r_word_cnt == CNT_W'(MAX_WORDS));
  assign w_store    = i_accept & ~w_full;
  assign o_drop_c   = i_accept & w_full;
  assign w_complete = w_store & (r_lane == LANE_W'(LANES - 1));
  assign w_flush_wr = i_flush & (r_lane != '0);
  assign w_base     = BASE_W'(r_lane) * BASE_W'(ELEM_W);

  // Buffer with the incoming element merged in, so a completing beat is written directly
  always_comb begin
    w_packed = r_buf;
    if (w_store) begin
      w_packed[w_base +: ELEM_W] = i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_lane     <= '0;
      r_buf      <= '0;
      r_word_cnt <= '0;
      r_wr       <= '0;
    end else begin
      r_wr.en <= 1'b0;
      if (i_clear) begin
        r_lane     <= '0;
        r_buf      <= '0;
        r_word_cnt <= '0;
      end else if (w_complete || w_flush_wr) begin
        // Address/data registers hold between strobes; only en is a pulse
        r_wr.en    <= 1'b1;
        r_wr.addr  <= ADDR_W'(r_word_cnt);
        r_wr.data  <= w_packed;
        r_word_cnt <= r_word_cnt + CNT_W'(1);
        r_lane     <= '0;
        r_buf      <= '0;
      end else if (w_store) begin
        r_buf  <= w_packed;
        r_lane <= r_lane + LANE_W'(1);
      end
    end
  end

  assign o_wr = r_wr;

endmodule

// File: rtl/spmv_csr_loader.sv
// Host-stream loader filling SRAM A / SRAM B with packed 256-bit words before SpMV runs.
// Optional running checksum of accepted elements: define SPMV_LOADER_CHECKSUM_EN.
module spmv_csr_loader
  import spmv_pkg::*;
#(
  parameter int unsigned MAX_WORDS_A = DEF_MAX_WORDS_A,
  parameter int unsigned MAX_WORDS_B = DEF_MAX_WORDS_B
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic              i_valid,
  input  logic [ELEM_W-1:0] i_data,
  input  logic              i_sel,
  input  logic              i_last,
  output logic              o_ready,
  output logic              o_wr_en_A,
  output logic [ADDR_W-1:0] o_address_A,
  output logic [WORD_W-1:0] o_write_data_A,
  output logic              o_wr_en_B,
  output logic [ADDR_W-1:0] o_address_B,
  output logic [WORD_W-1:0] o_write_data_B,
  output logic              o_overflow,
  output logic [ELEM_W-1:0] o_checksum,
  output logic [1:0]        o_state,
  output logic              o_done
);

  // Capping B below the result slot keeps RESULT_ADDR_B unwritable for any parameter choice
  localparam int unsigned LIMIT_B = min_words(MAX_WORDS_B, RESULT_ADDR_B);

  state_e   r_state;
  logic     r_ready;
  logic     r_done;
  logic     r_overflow;

  logic     w_accept;
  logic     w_clear;
  logic     w_flush;
  logic     w_drop_a;
  logic     w_drop_b;
  sram_wr_t w_wr_a;
  sram_wr_t w_wr_b;

  assign w_accept = i_valid & r_ready;
  assign w_clear  = (r_state == ST_IDLE) & i_start;
  assign w_flush  = (r_state == ST_FLUSH);

  spmv_word_packer #(
    .MAX_WORDS (MAX_WORDS_A)
  ) u_packer_a (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_clear  (w_clear),
    .i_accept (w_accept & ~i_sel),
    .i_data   (i_data),
    .i_flush  (w_flush),
    .o_drop_c (w_drop_a),
    .o_wr     (w_wr_a)
  );

  spmv_word_packer #(
    .MAX_WORDS (LIMIT_B)
  ) u_packer_b (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_clear  (w_clear),
    .i_accept (w_accept & i_sel),
    .i_data   (i_data),
    .i_flush  (w_flush),
    .o_drop_c (w_drop_b),
    .o_wr     (w_wr_b)
  );

  // Session FSM; ready/done/overflow are registered alongside the state
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state    <= ST_IDLE;
      r_ready    <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state    <= ST_LOAD;
            r_ready    <= 1'b1;
            r_overflow <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (w_drop_a || w_drop_b) begin
            r_overflow <= 1'b1;
          end
          if (w_accept && i_last) begin
            r_state <= ST_FLUSH;
            r_ready <= 1'b0;
          end
        end
        ST_FLUSH: begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPMV_LOADER_CHECKSUM_EN
  logic [ELEM_W-1:0] r_checksum;
  logic              w_keep;

  // Dropped elements never reach SRAM, so they are excluded from the sum
  assign w_keep = w_accept & ~(i_sel ? w_drop_b : w_drop_a);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_checksum <= '0;
    end else if (w_clear) begin
      r_checksum <= '0;
    end else if (w_keep) begin
      r_checksum <= r_checksum + i_data;
    end
  end

  assign o_checksum = r_checksum;
`else
  assign o_checksum = '0;
`endif

  assign o_ready        = r_ready;
  assign o_done         = r_done;
  assign o_overflow     = r_overflow;
  assign o_state        = r_state;
  assign o_wr_en_A      = w_wr_a.en;
  assign o_address_A    = w_wr_a.addr;
  assign o_write_data_A = w_wr_a.data;
  assign o_wr_en_B      = w_wr_b.en;
  assign o_address_B    = w_wr_b.addr;
  assign o_write_data_B = w_wr_b.data;

endmodule

// File: tb/tb_spmv_csr_loader.sv
// Self-checking bench for spmv_csr_loader: session table, random sessions against a
// word-level reference model, plus hand sequences for timing, checksum and mid-session reset.
module tb_spmv_csr_loader;

  logic         i_clk;
  logic         i_rstn;
  logic         i_start;
  logic         i_valid;
  logic [15:0]  i_data;
  logic         i_sel;
  logic         i_last;
  logic         o_ready;
  logic         o_wr_en_A;
  logic [4:0]   o_address_A;
  logic [255:0] o_write_data_A;
  logic         o_wr_en_B;
  logic [4:0]   o_address_B;
  logic [255:0] o_write_data_B;
  logic         o_overflow;
  logic [15:0]  o_checksum;
  logic [1:0]   o_state;
  logic         o_done;

  spmv_csr_loader dut (
    .i_clk          (i_clk),
    .i_rstn         (i_rstn),
    .i_start        (i_start),
    .i_valid        (i_valid),
    .i_data         (i_data),
    .i_sel          (i_sel),
    .i_last         (i_last),
    .o_ready        (o_ready),
    .o_wr_en_A      (o_wr_en_A),
    .o_address_A    (o_address_A),
    .o_write_data_A (o_write_data_A),
    .o_wr_en_B      (o_wr_en_B),
    .o_address_B    (o_address_B),
    .o_write_data_B (o_write_data_B),
    .o_overflow     (o_overflow),
    .o_checksum     (o_checksum),
    .o_state        (o_state),
    .o_done         (o_done)
  );

  localparam int CAP_A = 32 * 16;
  localparam int CAP_B = 16 * 16;

  typedef struct { logic [4:0] addr; logic [255:0] data; int cyc; } wr_t;
  typedef struct { bit sel; logic [15:0] data; bit last; } beat_t;
  typedef struct { int na; int nb; int wa; int wb; bit ovf; } vec_t;

  wr_t   act_a[$];
  wr_t   act_b[$];
  wr_t   exp_a[$];
  wr_t   exp_b[$];
  beat_t beats[$];
  int    done_cnt = 0;
  int    done_cyc = 0;
  int    cyc = 0;
  int    n_err = 0;
  int    n_chk = 0;
  logic        exp_ovf;
  logic [15:0] exp_cs;
  int    a0, b0, d0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Write/done monitor, sampled mid-cycle
  always @(negedge i_clk) begin
    if (i_rstn) begin
      if (o_wr_en_A) act_a.push_back('{o_address_A, o_write_data_A, cyc});
      if (o_wr_en_B) act_b.push_back('{o_address_B, o_write_data_B, cyc});
      if (o_done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
    end
  end

  task automatic chk(input string nm, input logic [263:0] act, input logic [263:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] word_of(input logic [15:0] el[$], input int w);
    logic [255:0] r = '0;
    for (int l = 0; l < 16; l++)
      if (w * 16 + l < el.size()) r[l*16 +: 16] = el[w*16 + l];
    return r;
  endfunction

  // Reference: per-target element lists, truncated to capacity, cut into 16-element words
  task automatic build_model();
    logic [15:0] ea[$];
    logic [15:0] eb[$];
    logic [15:0] sum = '0;
    foreach (beats[i]) begin
      if (beats[i].sel) eb.push_back(beats[i].data);
      else              ea.push_back(beats[i].data);
    end
    exp_ovf = (ea.size() > CAP_A) || (eb.size() > CAP_B);
    while (ea.size() > CAP_A) void'(ea.pop_back());
    while (eb.size() > CAP_B) void'(eb.pop_back());
    foreach (ea[i]) sum = sum + ea[i];
    foreach (eb[i]) sum = sum + eb[i];
`ifdef SPMV_LOADER_CHECKSUM_EN
    exp_cs = sum;
`else
    exp_cs = 16'h0000;
`endif
    exp_a.delete();
    exp_b.delete();
    for (int w = 0; w < (ea.size() + 15) / 16; w++) exp_a.push_back('{5'(w), word_of(ea, w), 0});
    for (int w = 0; w < (eb.size() + 15) / 16; w++) exp_b.push_back('{5'(w), word_of(eb, w), 0});
  endtask

  task automatic add_beat(input bit s, input logic [15:0] d);
    beats.push_back('{s, d, 1'b0});
  endtask

  task automatic mark_last();
    beat_t b = beats.pop_back();
    b.last = 1'b1;
    beats.push_back(b);
  endtask

  task automatic start_session(input string nm);
    a0 = act_a.size(); b0 = act_b.size(); d0 = done_cnt;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    chk({nm, ".ready"}, 264'(o_ready), 264'(1));
  endtask

  task automatic drive(input bit gaps);
    foreach (beats[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        i_valid = 1'b0; i_data = 16'($urandom); i_sel = 1'($urandom); i_last = 1'($urandom);
        @(posedge i_clk); #1;
      end
      i_valid = 1'b1; i_sel = beats[i].sel; i_data = beats[i].data; i_last = beats[i].last;
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  task automatic run_session(input string nm, input bit gaps, input int wa, input int wb);
    int na, nb;
    build_model();
    if (gaps) begin
      // Valid beats while idle must be ignored
      i_valid = 1'b1; i_sel = 1'($urandom); i_data = 16'($urandom); i_last = 1'b1;
      repeat (2) @(posedge i_clk);
      #1 i_valid = 1'b0; i_last = 1'b0;
    end
    start_session(nm);
    drive(gaps);
    for (int t = 0; t < 10; t++) begin
      @(negedge i_clk);
      if (done_cnt > d0) break;
    end
    repeat (3) @(negedge i_clk);
    chk({nm, ".done_once"}, 264'(done_cnt - d0), 264'(1));
    na = act_a.size() - a0;
    nb = act_b.size() - b0;
    chk({nm, ".nwr_a"}, 264'(na), 264'(exp_a.size()));
    chk({nm, ".nwr_b"}, 264'(nb), 264'(exp_b.size()));
    if (wa >= 0) chk({nm, ".nwr_a_tbl"}, 264'(na), 264'(wa));
    if (wb >= 0) chk({nm, ".nwr_b_tbl"}, 264'(nb), 264'(wb));
    for (int i = 0; i < na && i < exp_a.size(); i++)
      chk($sformatf("%s.wr_a[%0d]", nm, i), {act_a[a0+i].addr, act_a[a0+i].data},
          {exp_a[i].addr, exp_a[i].data});
    for (int i = 0; i < nb && i < exp_b.size(); i++)
      chk($sformatf("%s.wr_b[%0d]", nm, i), {act_b[b0+i].addr, act_b[b0+i].data},
          {exp_b[i].addr, exp_b[i].data});
    if (exp_b.size() > 0)
      chk({nm, ".hold_b"}, {o_address_B, o_write_data_B},
          {exp_b[exp_b.size()-1].addr, exp_b[exp_b.size()-1].data});
    chk({nm, ".overflow"}, 264'(o_overflow), 264'(exp_ovf));
    chk({nm, ".checksum"}, 264'(o_checksum), 264'(exp_cs));
    chk({nm, ".state_idle"}, 264'(o_state), 264'(0));
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, ".ready"},   264'(o_ready), 264'(0));
    chk({nm, ".state"},   264'(o_state), 264'(0));
    chk({nm, ".done"},    264'(o_done), 264'(0));
    chk({nm, ".ovf"},     264'(o_overflow), 264'(0));
    chk({nm, ".cs"},      264'(o_checksum), 264'(0));
    chk({nm, ".port_a"},  {o_wr_en_A, o_address_A, o_write_data_A}, 264'(0));
    chk({nm, ".port_b"},  {o_wr_en_B, o_address_B, o_write_data_B}, 264'(0));
  endtask

  initial begin
    vec_t tbl[7];
    int   ia, ib, n;
    tbl[0] = '{16,  0,   1,  0, 1'b0};
    tbl[1] = '{0,   20,  0,  2, 1'b0};
    tbl[2] = '{3,   3,   1,  1, 1'b0};
    tbl[3] = '{0,   272, 0,  16, 1'b1};
    tbl[4] = '{17,  1,   2,  1, 1'b0};
    tbl[5] = '{512, 0,   32, 0, 1'b0};
    tbl[6] = '{513, 0,   32, 0, 1'b1};

    i_rstn = 1'b0; i_start = 1'b0; i_valid = 1'b0; i_data = '0; i_sel = 1'b0; i_last = 1'b0;
    repeat (3) @(posedge i_clk);
    #1 check_all_zero("reset");
    @(negedge i_clk) i_rstn = 1'b1;
    @(posedge i_clk); #1;

    // Table sessions: A/B interleaved, element k of each target carries k+1
    foreach (tbl[t]) begin
      beats.delete();
      ia = 0; ib = 0;
      while (ia < tbl[t].na || ib < tbl[t].nb) begin
        if (ia < tbl[t].na) begin add_beat(1'b0, 16'(ia + 1)); ia++; end
        if (ib < tbl[t].nb) begin add_beat(1'b1, 16'(ib + 1)); ib++; end
      end
      mark_last();
      run_session($sformatf("tbl%0d", t), 1'b0, tbl[t].wa, tbl[t].wb);
      chk($sformatf("tbl%0d.ovf_tbl", t), 264'(o_overflow), 264'(tbl[t].ovf));
      if (t == 0 && act_a.size() > 0)
        chk("tbl0.done_after_write", 264'(done_cyc), 264'(act_a[act_a.size()-1].cyc + 1));
      if (t == 2 && act_a.size() > 0 && act_b.size() > 0) begin
        chk("tbl2.same_cycle_ab", 264'(act_a[act_a.size()-1].cyc), 264'(act_b[act_b.size()-1].cyc));
        chk("tbl2.flush_with_done", 264'(act_a[act_a.size()-1].cyc), 264'(done_cyc));
      end
    end

    // Random sessions with idle gaps and noise on unqualified inputs
    for (int s = 0; s < 12; s++) begin
      beats.delete();
      n = $urandom_range(1, 80);
      for (int k = 0; k < n; k++) add_beat(1'($urandom), 16'($urandom));
      mark_last();
      run_session($sformatf("rnd%0d", s), 1'b1, -1, -1);
    end

    // Checksum wrap: 0xFFFF + 0x0002
    beats.delete();
    add_beat(1'b0, 16'hFFFF);
    add_beat(1'b0, 16'h0002);
    mark_last();
    run_session("cksum", 1'b0, 1, 0);
`ifdef SPMV_LOADER_CHECKSUM_EN
    chk("cksum.value", 264'(o_checksum), 264'(16'h0001));
`else
    chk("cksum.value", 264'(o_checksum), 264'(16'h0000));
`endif

    // Reset after 8 A beats: nothing written, everything back to zero
    beats.delete();
    for (int k = 0; k < 8; k++) add_beat(1'b0, 16'(16'h100 + k));
    start_session("midrst");
    drive(1'b0);
    i_rstn = 1'b0;
    #2 check_all_zero("midrst");
    chk("midrst.no_write", 264'(act_a.size() - a0), 264'(0));
    @(negedge i_clk) i_rstn = 1'b1;
    @(posedge i_clk); #1;
    beats.delete();
    for (int k = 0; k < 16; k++) add_beat(1'b0, 16'(16'h200 + k));
    mark_last();
    run_session("after_rst", 1'b0, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
